fix_serializer: RTL and testbench
=================================

FIX_SERIALIZER -- requirements
Module: fix_serializer

Interface
REQ-001 The block SHALL have these parameters, one per line:
- MAX_BYTES, default 8, byte-buffer depth (fixed at 8; other values are unsupported).
- SOH, default 8'h01, field delimiter byte.
- EQ, default 8'h3D, tag/value separator byte.

REQ-002 The block SHALL have these ports, one per line:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid_i  in  1  input chunk valid.
- in_ready_o  out  1  input chunk accepted when high with in_valid_i.
- in_data_i  in  32  ASCII chunk; first byte in [31:24].
- in_bytes_i  in  3  valid byte count of the chunk, 1..4, MSB-aligned.
- in_kind_i  in  1  0 = tag bytes, 1 = value bytes.
- in_last_i  in  1  last chunk of the current tag or value.
- msg_end_i  in  1  with a value last chunk: end of message, flush.
- data_o  out  32  packed output word; first byte in [31:24].
- data_bytes_o  out  3  valid bytes in data_o, 1..4.
- data_valid_o  out  1  output word valid.
- data_ready_i  in  1  downstream accepts the word.
- error_o  out  1  sticky protocol error.
- checksum_o  out  8  FIX checksum of the last completed message.

Function
REQ-003 The FSM SHALL have the states EXPECT_TAG, IN_TAG, IN_VALUE and FLUSH; its reset state is EXPECT_TAG.
REQ-004 EXPECT_TAG SHALL move to IN_TAG on an accepted tag chunk.
REQ-005 IN_TAG SHALL append EQ after a tag chunk with in_last_i=1 and then move to IN_VALUE.
REQ-006 In IN_VALUE, a value chunk with in_last_i=1 SHALL append SOH; with msg_end_i=1 the FSM SHALL go to FLUSH, otherwise to EXPECT_TAG.
REQ-007 A chunk of the wrong kind for the state, or in_bytes_i of 0 or greater than 4, SHALL set error_o, be dropped, and leave the state unchanged; error_o SHALL clear only on reset.
REQ-008 Accepted bytes SHALL be appended in order to an 8-byte buffer; the occupancy count SHALL be 0..8.
REQ-009 in_ready_o SHALL be high only when count is at most 3 and the state is not FLUSH, so a chunk plus its delimiter (at most 5 bytes) always fits.
REQ-010 data_valid_o SHALL be registered and high when count is at least 4 (data_bytes_o=4), or in FLUSH when count is 1..3 (data_bytes_o=count, unused low bytes 0).
REQ-011 On data_valid_o and data_ready_i, the emitted bytes SHALL be removed and the remainder shifted to the head in the same cycle; accept and emit in one cycle SHALL be supported.
REQ-012 data_o, data_bytes_o and data_valid_o SHALL hold stable while data_valid_o=1 and data_ready_i=0.
REQ-013 FLUSH SHALL return to EXPECT_TAG the cycle after the buffer reaches count 0.
REQ-014 Latency SHALL be 1 cycle: a word completed by a chunk accepted on edge N SHALL be valid after edge N.
REQ-015 msg_end_i SHALL be ignored unless the chunk is value kind with in_last_i=1.

Reset
REQ-016 While rst=0, all of the following SHALL hold asynchronously: state=EXPECT_TAG, count=0, buffer=0, data_o=0, data_bytes_o=0, data_valid_o=0, in_ready_o=0, error_o=0, checksum_o=0.
REQ-017 in_ready_o SHALL rise on the first clk edge after rst deasserts.
REQ-018 Reset mid-message SHALL discard all buffered bytes without emitting them.

Configuration
REQ-019 With FIX_CHECKSUM_EN defined, a running sum mod 256 of every byte entering the buffer (delimiters included) SHALL be kept; at the SOH of a msg_end_i chunk it SHALL load checksum_o and the running sum SHALL clear to 0.
REQ-020 Without FIX_CHECKSUM_EN, checksum_o SHALL be constant 0 and no adder logic SHALL be present.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Tag 0x32320000 (bytes 2, last), then value 0x33330000 (bytes 2, last, msg_end), data_ready_i=1 -> 0x32323D33 (bytes 4), then 0x33010000 (bytes 2); checksum_o=0x08 when enabled.
- Tag "8" plus value "FIX.4.2" as chunks 0x4649582E and 0x342E3200 (bytes 3) -> 0x383D4649, 0x582E342E, 0x3201 partial flush.
- data_ready_i=0 for 5 cycles with count 8 -> in_ready_o=0, data_o stable; release -> no byte lost or duplicated.
- Value chunk in EXPECT_TAG -> error_o=1, output stream unchanged, following valid field serialized correctly.
- rst pulsed low with count 3 -> outputs 0 immediately; next message starts at byte 0.
- in_bytes_i=0 -> error_o=1, chunk dropped.

Source files
------------

// File: rtl/fix_serializer.sv
// fix_serializer: packs FIX tag/value chunks, inserting '=' and SOH delimiters, into 32-bit words.
// Define FIX_CHECKSUM_EN to keep a running mod-256 byte sum and publish it per message on checksum_o.
module fix_serializer #(
  parameter int unsigned MAX_BYTES = 8,
  parameter logic [7:0]  SOH       = 8'h01,
  parameter logic [7:0]  EQ        = 8'h3D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data_i,
  input  logic [2:0]  in_bytes_i,
  input  logic        in_kind_i,
  input  logic        in_last_i,
  input  logic        msg_end_i,
  output logic [31:0] data_o,
  output logic [2:0]  data_bytes_o,
  output logic        data_valid_o,
  input  logic        data_ready_i,
  output logic        error_o,
  output logic [7:0]  checksum_o
);
  localparam int unsigned BUF_W = 8 * MAX_BYTES;

  typedef enum logic [1:0] {EXPECT_TAG, IN_TAG, IN_VALUE, FLUSH} state_t;

  state_t           r_state, w_state_nx;
  logic [BUF_W-1:0] r_buf, w_shift, w_place, w_buf_nx;
  logic [3:0]       r_count, w_keep, w_count_nx;
  logic [31:0]      r_data;
  logic [2:0]       r_data_bytes;
  logic             r_data_valid, r_in_ready, r_error;

  logic        w_accept, w_emit, w_bytes_ok, w_kind_ok, w_good, w_bad, w_last, w_msg_end;
  logic        w_valid_nx;
  logic [2:0]  w_emit_n, w_app_n;
  logic [7:0]  w_delim;
  logic [39:0] w_app, w_app_mask, w_app_masked;

  assign w_accept   = in_valid_i && r_in_ready;
  assign w_emit     = r_data_valid && data_ready_i;
  assign w_bytes_ok = (in_bytes_i != 3'd0) && (in_bytes_i <= 3'd4);

  always_comb begin
    unique case (r_state)
      EXPECT_TAG, IN_TAG: w_kind_ok = !in_kind_i;
      IN_VALUE:           w_kind_ok = in_kind_i;
      default:            w_kind_ok = 1'b0;
    endcase
  end

  assign w_good    = w_accept && w_bytes_ok && w_kind_ok;
  assign w_bad     = w_accept && !(w_bytes_ok && w_kind_ok);
  assign w_last    = w_good && in_last_i;
  assign w_msg_end = w_last && in_kind_i && msg_end_i;

  // Bytes leaving the head this cycle, and what stays behind before new bytes land.
  assign w_emit_n = !w_emit ? 3'd0 : (r_count >= 4'd4) ? 3'd4 : r_count[2:0];
  assign w_keep   = r_count - {1'b0, w_emit_n};
  assign w_app_n  = !w_good ? 3'd0 : in_bytes_i + {2'b00, in_last_i};
  assign w_delim  = in_kind_i ? SOH : EQ;

  always_comb begin
    // NOTE: default first so the partial-chunk loop below cannot infer a latch.
    w_app = {5{w_delim}};
    for (int k = 0; k < 4; k++)
      if (3'(k) < in_bytes_i) w_app[39-8*k -: 8] = in_data_i[31-8*k -: 8];
  end

  assign w_app_mask   = ~(40'hFF_FFFF_FFFF >> {w_app_n, 3'b000});
  assign w_app_masked = w_app & w_app_mask;

  // Slots past the occupancy count are always zero, so shift-then-OR appends in place.
  assign w_shift    = r_buf << {w_emit_n, 3'b000};
  assign w_place    = {w_app_masked, {(BUF_W-40){1'b0}}} >> {w_keep, 3'b000};
  assign w_buf_nx   = w_shift | w_place;
  assign w_count_nx = w_keep + {1'b0, w_app_n};

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      EXPECT_TAG, IN_TAG: if (w_good) w_state_nx = in_last_i ? IN_VALUE : IN_TAG;
      IN_VALUE:           if (w_last) w_state_nx = w_msg_end ? FLUSH : EXPECT_TAG;
      FLUSH:              if (r_count == 4'd0) w_state_nx = EXPECT_TAG;
    endcase
  end

  assign w_valid_nx = (w_count_nx >= 4'd4) || ((w_state_nx == FLUSH) && (w_count_nx != 4'd0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= EXPECT_TAG;
      r_count      <= '0;
      // NOTE: the byte buffer is reset as well: it drops a half-built message and keeps unused slots zero.
      r_buf        <= '0;
      r_data       <= '0;
      r_data_bytes <= '0;
      r_data_valid <= 1'b0;
      r_in_ready   <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values computed above.
      r_state      <= w_state_nx;
      r_count      <= w_count_nx;
      r_buf        <= w_buf_nx;
      r_data_valid <= w_valid_nx;
      r_data       <= w_valid_nx ? w_buf_nx[BUF_W-1 -: 32] : 32'h0;
      r_data_bytes <= !w_valid_nx ? 3'd0 : (w_count_nx >= 4'd4) ? 3'd4 : w_count_nx[2:0];
      r_in_ready   <= (w_count_nx <= 4'd3) && (w_state_nx != FLUSH);
      if (w_bad) r_error <= 1'b1;
    end
  end

  assign in_ready_o   = r_in_ready;
  assign data_o       = r_data;
  assign data_bytes_o = r_data_bytes;
  assign data_valid_o = r_data_valid;
  assign error_o      = r_error;

`ifdef FIX_CHECKSUM_EN
  logic [7:0] r_sum, r_checksum, w_sum_nx;

  always_comb begin
    w_sum_nx = r_sum;
    for (int k = 0; k < 5; k++) w_sum_nx = w_sum_nx + w_app_masked[39-8*k -: 8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum      <= '0;
      r_checksum <= '0;
    end else if (w_msg_end) begin
      r_checksum <= w_sum_nx;
      r_sum      <= '0;
    end else begin
      r_sum      <= w_sum_nx;
    end
  end

  assign checksum_o = r_checksum;
`else
  assign checksum_o = 8'h00;
`endif

endmodule

// File: tb/tb_fix_serializer.sv
// tb_fix_serializer: a byte-stream model queues every expected output word as chunks are accepted;
// a monitor pops and compares each word the DUT hands over.
module tb_fix_serializer;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i, in_kind_i, in_last_i, msg_end_i, data_ready_i;
  logic        in_ready_o, data_valid_o, error_o;
  logic [31:0] in_data_i, data_o;
  logic [2:0]  in_bytes_i, data_bytes_o;
  logic [7:0]  checksum_o;
  bit          rand_ready;

`ifdef FIX_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  fix_serializer dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .in_bytes_i(in_bytes_i), .in_kind_i(in_kind_i), .in_last_i(in_last_i),
    .msg_end_i(msg_end_i), .data_o(data_o), .data_bytes_o(data_bytes_o),
    .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
    .error_o(error_o), .checksum_o(checksum_o)
  );

  typedef struct {
    logic [31:0] data;
    logic [2:0]  nbytes;
  } word_t;

  word_t      exp_q[$];
  word_t      obs_q[$];
  logic [7:0] m_bytes[$];
  bit         m_in_value, m_err;
  logic [7:0] m_sum, m_chk;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: a word seen valid with ready at the falling edge transfers on the next rising edge.
  always @(negedge clk) begin
    if (rst === 1'b1 && data_valid_o === 1'b1 && data_ready_i === 1'b1) begin
      word_t o, e;
      o.data = data_o;
      o.nbytes = data_bytes_o;
      obs_q.push_back(o);
      check("word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("word_data", o.data, e.data);
        check("word_bytes", 32'(o.nbytes), 32'(e.nbytes));
      end
    end
  end

  function automatic void model_emit(input bit flush);
    word_t w;
    while (m_bytes.size() >= 4) begin
      w.data   = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
      w.nbytes = 3'd4;
      repeat (4) void'(m_bytes.pop_front());
      exp_q.push_back(w);
    end
    if (flush && m_bytes.size() != 0) begin
      w.data   = 32'h0;
      w.nbytes = 3'(m_bytes.size());
      for (int i = 0; i < m_bytes.size(); i++) w.data[31-8*i -: 8] = m_bytes[i];
      m_bytes.delete();
      exp_q.push_back(w);
    end
  endfunction

  function automatic void model_chunk(input logic [31:0] d, input logic [2:0] nb,
                                      input bit kind, input bit last, input bit me);
    logic [7:0] b;
    if (nb == 3'd0 || nb > 3'd4 || kind != m_in_value) begin
      m_err = 1'b1;
      return;
    end
    for (int k = 0; k < int'(nb); k++) begin
      b = d[31-8*k -: 8];
      m_bytes.push_back(b);
      m_sum += b;
    end
    if (last) begin
      b = kind ? 8'h01 : 8'h3D;
      m_bytes.push_back(b);
      m_sum += b;
      if (!kind) m_in_value = 1'b1;
      else begin
        m_in_value = 1'b0;
        if (me) begin
          m_chk = m_sum;
          m_sum = 8'h00;
        end
      end
    end
    model_emit(last && kind && me);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) data_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [31:0] d, input logic [2:0] nb, input logic kind,
                      input logic last, input logic me);
    int cyc = 0;
    bit acc = 1'b0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_bytes_i = nb;
    in_kind_i  = kind;
    in_last_i  = last;
    msg_end_i  = me;
    while (!acc && cyc < 300) begin
      @(negedge clk);
      acc = in_ready_o;
      tick();
      cyc++;
    end
    in_valid_i = 1'b0;
    check("chunk_accepted", 32'(acc), 32'd1);
    if (acc) begin
      model_chunk(d, nb, kind, last, me);
      check("error_o", 32'(error_o), 32'(m_err));
    end
  endtask

  task automatic drain(input string tag);
    int cyc = 0;
    if (!rand_ready) data_ready_i = 1'b1;
    while ((exp_q.size() != 0 || in_ready_o !== 1'b1) && cyc < 600) begin
      tick();
      cyc++;
    end
    tick();
    tick();
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic expect_word(input string tag, input int idx, input logic [31:0] d,
                             input logic [2:0] nb);
    if (idx < obs_q.size()) begin
      check({tag, "_data"}, obs_q[idx].data, d);
      check({tag, "_bytes"}, 32'(obs_q[idx].nbytes), 32'(nb));
    end
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    in_valid_i = 1'b0;
    #1;
    check("rst_data_valid", 32'(data_valid_o), 32'd0);
    check("rst_data", data_o, 32'h0);
    check("rst_data_bytes", 32'(data_bytes_o), 32'd0);
    check("rst_in_ready", 32'(in_ready_o), 32'd0);
    check("rst_error", 32'(error_o), 32'd0);
    check("rst_checksum", 32'(checksum_o), 32'd0);
    exp_q.delete();
    m_bytes.delete();
    m_in_value = 1'b0;
    m_err      = 1'b0;
    m_sum      = 8'h00;
    m_chk      = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("ready_before_first_edge", 32'(in_ready_o), 32'd0);
    tick();
    check("ready_after_first_edge", 32'(in_ready_o), 32'd1);
  endtask

  task automatic scenario_22_33(input string tag);
    obs_q.delete();
    send(32'h3232_0000, 3'd2, 1'b0, 1'b1, 1'b0);
    send(32'h3333_0000, 3'd2, 1'b1, 1'b1, 1'b1);
    drain(tag);
    check({tag, "_nwords"}, 32'(obs_q.size()), 32'd2);
    expect_word({tag, "_w0"}, 0, 32'h3232_3D33, 3'd4);
    expect_word({tag, "_w1"}, 1, 32'h3301_0000, 3'd2);
    check({tag, "_checksum"}, 32'(checksum_o), CHK_EN ? 32'h08 : 32'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_valid_i   = 1'b0;
    in_data_i    = 32'h0;
    in_bytes_i   = 3'd0;
    in_kind_i    = 1'b0;
    in_last_i    = 1'b0;
    msg_end_i    = 1'b0;
    data_ready_i = 1'b1;
    rand_ready   = 1'b0;
    do_reset();

    scenario_22_33("s1");

    // "8=FIX.4.2|" with the value split into 4- and 3-byte chunks
    obs_q.delete();
    send(32'h3800_0000, 3'd1, 1'b0, 1'b1, 1'b0);
    send(32'h4649_582E, 3'd4, 1'b1, 1'b0, 1'b0);
    send(32'h342E_3200, 3'd3, 1'b1, 1'b1, 1'b1);
    drain("s2");
    check("s2_nwords", 32'(obs_q.size()), 32'd3);
    expect_word("s2_w0", 0, 32'h383D_4649, 3'd4);
    expect_word("s2_w1", 1, 32'h582E_342E, 3'd4);
    expect_word("s2_w2", 2, 32'h3201_0000, 3'd2);
    check("s2_checksum", 32'(checksum_o), 32'(CHK_EN ? m_chk : 8'h00));

    // Backpressure with a full buffer
    data_ready_i = 1'b0;
    send(32'h4142_4300, 3'd3, 1'b0, 1'b0, 1'b0);
    send(32'h4445_4647, 3'd4, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready_o), 32'd0);
      check("bp_valid", 32'(data_valid_o), 32'd1);
      check("bp_data", data_o, 32'h4142_4344);
      check("bp_bytes", 32'(data_bytes_o), 32'd4);
      tick();
    end
    data_ready_i = 1'b1;
    send(32'h3100_0000, 3'd1, 1'b1, 1'b1, 1'b1);
    drain("bp");

    // Wrong-kind chunk: dropped, sticky error, stream unaffected
    check("s4_error_before", 32'(error_o), 32'd0);
    obs_q.delete();
    send(32'h5500_0000, 3'd1, 1'b1, 1'b1, 1'b1);
    repeat (4) tick();
    check("s4_error_set", 32'(error_o), 32'd1);
    check("s4_no_output", 32'(obs_q.size()), 32'd0);
    send(32'h3335_0000, 3'd2, 1'b0, 1'b1, 1'b0);
    send(32'h4100_0000, 3'd1, 1'b1, 1'b1, 1'b1);
    drain("s4");
    check("s4_error_sticky", 32'(error_o), 32'd1);

    // Reset with three bytes buffered
    send(32'h3132_3300, 3'd3, 1'b0, 1'b0, 1'b0);
    #2;
    check("s5_nothing_emitted", 32'(data_valid_o), 32'd0);
    do_reset();
    scenario_22_33("s5");

    // Byte counts of 0 and 5 are rejected
    obs_q.delete();
    send(32'h3100_0000, 3'd0, 1'b0, 1'b1, 1'b0);
    check("s6_error_bytes0", 32'(error_o), 32'd1);
    send(32'h3132_3334, 3'd5, 1'b0, 1'b1, 1'b0);
    send(32'h3900_0000, 3'd1, 1'b0, 1'b1, 1'b0);
    send(32'h3737_0000, 3'd2, 1'b1, 1'b1, 1'b1);
    drain("s6");
    check("s6_nwords", 32'(obs_q.size()), 32'd2);

    // Random messages under random downstream readiness
    do_reset();
    rand_ready = 1'b1;
    for (int m = 0; m < 12; m++) begin
      int nf;
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        int nt, nv;
        nt = $urandom_range(1, 2);
        nv = $urandom_range(1, 3);
        for (int c = 0; c < nt; c++)
          send($urandom(), 3'($urandom_range(1, 4)), 1'b0, 1'(c == nt - 1), 1'($urandom_range(0, 1)));
        for (int c = 0; c < nv; c++)
          send($urandom(), 3'($urandom_range(1, 4)), 1'b1, 1'(c == nv - 1),
               (c == nv - 1) ? 1'(f == nf - 1) : 1'($urandom_range(0, 1)));
      end
      drain("rand");
      check("rand_checksum", 32'(checksum_o), 32'(CHK_EN ? m_chk : 8'h00));
    end
    rand_ready = 1'b0;
    check("rand_error_clear", 32'(error_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
